// File: rtl/cpu_muldiv_sequencer.sv
// Sequencer between execute and the shared iterative multiply/divide units.
// Define CPU_MULDIV_REUSE_EN to reuse the last unit result when class and operands match.
module cpu_muldiv_sequencer (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_request,
   input  logic [2:0]  i_op,
   input  logic [31:0] i_op1,
   input  logic [31:0] i_op2,
   output logic        o_busy,
   output logic        o_ready,
   output logic [31:0] o_result,
   output logic [31:0] o_unit_op1,
   output logic [31:0] o_unit_op2,
   output logic        o_mul_latch,
   output logic        o_mul_signed,
   input  logic        i_mul_ready,
   input  logic [63:0] i_mul_result,
   output logic        o_div_latch,
   output logic        o_div_signed,
   input  logic        i_div_ready,
   input  logic [31:0] i_div_result,
   input  logic [31:0] i_div_remainder
);

   typedef enum logic [1:0] {IDLE, LATCH, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] op1_q, op1_d;
   logic [31:0] op2_q, op2_d;
   logic [31:0] result_q, result_d;

   logic        div_zero, div_ovf, fast_path;
   logic [31:0] fast_result;
   logic        unit_ready, wait_done;
   logic [63:0] unit_data;
   logic        reuse_hit;
   logic [63:0] reuse_data;

   function automatic logic op_signed(input logic [2:0] op);
      return op[2] ? ~op[0] : ~op[1];
   endfunction

   // Divider data is packed as {remainder, quotient} so both units share one selector.
   function automatic logic [31:0] select_result(input logic [2:0]  op,
                                                 input logic [63:0] data,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
      logic [31:0] r;
      case (op)
         3'd0, 3'd4, 3'd5: r = data[31:0];
         3'd2:             r = data[63:32] - (a[31] ? b : 32'd0);
         default:          r = data[63:32];
      endcase
      return r;
   endfunction

   always_comb begin
      div_zero    = i_op[2] && (i_op2 == 32'd0);
      div_ovf     = i_op[2] && !i_op[0] && (i_op1 == 32'h8000_0000) && (i_op2 == 32'hFFFF_FFFF);
      fast_path   = div_zero || div_ovf;
      fast_result = 32'd0;
      if (div_zero) begin
         fast_result = i_op[1] ? i_op1 : 32'hFFFF_FFFF;
      end else begin
         fast_result = i_op[1] ? 32'd0 : 32'h8000_0000;
      end
   end

   assign unit_ready = op_q[2] ? i_div_ready : i_mul_ready;
   assign unit_data  = op_q[2] ? {i_div_remainder, i_div_result} : i_mul_result;
   assign wait_done  = (state_q == WAIT) && unit_ready;

`ifdef CPU_MULDIV_REUSE_EN
   logic        tag_valid_q, tag_valid_d;
   logic        tag_div_q, tag_div_d;
   logic        tag_signed_q, tag_signed_d;
   logic [31:0] tag_op1_q, tag_op1_d;
   logic [31:0] tag_op2_q, tag_op2_d;
   logic [63:0] tag_data_q, tag_data_d;

   always_comb begin
      tag_valid_d  = tag_valid_q;
      tag_div_d    = tag_div_q;
      tag_signed_d = tag_signed_q;
      tag_op1_d    = tag_op1_q;
      tag_op2_d    = tag_op2_q;
      tag_data_d   = tag_data_q;
      if (wait_done) begin
         tag_valid_d  = 1'b1;
         tag_div_d    = op_q[2];
         tag_signed_d = op_signed(op_q);
         tag_op1_d    = op1_q;
         tag_op2_d    = op2_q;
         tag_data_d   = unit_data;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         tag_valid_q  <= 1'b0;
         tag_div_q    <= 1'b0;
         tag_signed_q <= 1'b0;
         tag_op1_q    <= 32'd0;
         tag_op2_q    <= 32'd0;
         tag_data_q   <= 64'd0;
      end else begin
         tag_valid_q  <= tag_valid_d;
         tag_div_q    <= tag_div_d;
         tag_signed_q <= tag_signed_d;
         tag_op1_q    <= tag_op1_d;
         tag_op2_q    <= tag_op2_d;
         tag_data_q   <= tag_data_d;
      end
   end

   assign reuse_hit  = tag_valid_q && (tag_div_q == i_op[2]) && (tag_signed_q == op_signed(i_op))
                       && (tag_op1_q == i_op1) && (tag_op2_q == i_op2);
   assign reuse_data = tag_data_q;
`else
   assign reuse_hit  = 1'b0;
   assign reuse_data = 64'd0;
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (i_request) begin
               op_d  = i_op;
               op1_d = i_op1;
               op2_d = i_op2;
               if (fast_path) begin
                  result_d = fast_result;
                  state_d  = DONE;
               end else if (reuse_hit) begin
                  result_d = select_result(i_op, reuse_data, i_op1, i_op2);
                  state_d  = DONE;
               end else begin
                  state_d = LATCH;
               end
            end
         end
         LATCH: state_d = WAIT;
         WAIT: begin
            if (unit_ready) begin
               result_d = select_result(op_q, unit_data, op1_q, op2_q);
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q  <= IDLE;
         op_q     <= 3'd0;
         op1_q    <= 32'd0;
         op2_q    <= 32'd0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         result_q <= result_d;
      end
   end

   // Signedness is only meaningful while a unit owns the operands; elsewhere it reads 0.
   assign o_busy       = i_request || (state_q != IDLE);
   assign o_ready      = (state_q == DONE);
   assign o_result     = result_q;
   assign o_unit_op1   = op1_q;
   assign o_unit_op2   = op2_q;
   assign o_mul_latch  = (state_q == LATCH) && !op_q[2];
   assign o_div_latch  = (state_q == LATCH) && op_q[2];
   assign o_mul_signed = ((state_q == LATCH) || (state_q == WAIT)) && !op_q[2] && op_signed(op_q);
   assign o_div_signed = ((state_q == LATCH) || (state_q == WAIT)) && op_q[2] && op_signed(op_q);

endmodule

// File: tb/tb_cpu_muldiv_sequencer.sv
// Scoreboard bench for cpu_muldiv_sequencer with behavioural multiply/divide units.
module tb_cpu_muldiv_sequencer;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 6;
`ifdef CPU_MULDIV_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_request = 1'b0;
   logic [2:0]  i_op = 3'd0;
   logic [31:0] i_op1 = 32'd0, i_op2 = 32'd0;
   logic        o_busy, o_ready, o_mul_latch, o_mul_signed, o_div_latch, o_div_signed;
   logic [31:0] o_result, o_unit_op1, o_unit_op2;
   logic        mulReady, divReady;
   logic [63:0] mulProd = 64'd0;
   logic [31:0] divQ = 32'd0, divR = 32'd0;
   int          mulCnt = 0, divCnt = 0;

   typedef struct {
      logic [31:0] result;
      int          cycle;
      string       name;
   } exp_t;
   exp_t sb[$];

   int          tests = 0, fails = 0, cycle = 0, acceptCycle = 0;
   int          mulLatches = 0, divLatches = 0;
   logic [2:0]  curOp = 3'd0;
   logic [31:0] curA = 32'd0, curB = 32'd0;

   cpu_muldiv_sequencer dut (
      .i_clock(clock), .i_reset(i_reset), .i_request(i_request), .i_op(i_op),
      .i_op1(i_op1), .i_op2(i_op2), .o_busy(o_busy), .o_ready(o_ready),
      .o_result(o_result), .o_unit_op1(o_unit_op1), .o_unit_op2(o_unit_op2),
      .o_mul_latch(o_mul_latch), .o_mul_signed(o_mul_signed),
      .i_mul_ready(mulReady), .i_mul_result(mulProd),
      .o_div_latch(o_div_latch), .o_div_signed(o_div_signed),
      .i_div_ready(divReady), .i_div_result(divQ), .i_div_remainder(divR)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cycle++;

   // Behavioural units: ready drops the cycle after the latch and rises after the latency.
   assign mulReady = (mulCnt == 0);
   assign divReady = (divCnt == 0);

   always @(posedge clock) begin
      if (o_mul_latch) begin
         mulCnt  <= MUL_LAT;
         mulProd <= (o_mul_signed ? {{32{o_unit_op1[31]}}, o_unit_op1} : {32'd0, o_unit_op1})
                  * (o_mul_signed ? {{32{o_unit_op2[31]}}, o_unit_op2} : {32'd0, o_unit_op2});
      end else if (mulCnt != 0) begin
         mulCnt <= mulCnt - 1;
      end
   end

   always @(posedge clock) begin
      if (o_div_latch) begin
         divCnt <= DIV_LAT;
         if (o_div_signed) begin
            divQ <= $signed(o_unit_op1) / $signed(o_unit_op2);
            divR <= $signed(o_unit_op1) % $signed(o_unit_op2);
         end else begin
            divQ <= o_unit_op1 / o_unit_op2;
            divR <= o_unit_op1 % o_unit_op2;
         end
      end else if (divCnt != 0) begin
         divCnt <= divCnt - 1;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every result pulse and checks latch pulses.
   always @(negedge clock) begin
      if (o_ready) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_ready", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput({e.name, "_result"}, {32'd0, o_result}, {32'd0, e.result});
            checkOutput({e.name, "_latency"}, 64'(cycle), 64'(e.cycle));
            checkOutput({e.name, "_busy_in_done"}, {63'd0, o_busy}, 64'd1);
         end
      end
      if (o_mul_latch) begin
         mulLatches++;
         checkOutput("mul_latch_cycle", 64'(cycle), 64'(acceptCycle + 1));
         checkOutput("mul_signed", {63'd0, o_mul_signed}, {63'd0, (curOp == 3'd0 || curOp == 3'd1)});
         checkOutput("mul_unit_ops", {o_unit_op1, o_unit_op2}, {curA, curB});
      end
      if (o_div_latch) begin
         divLatches++;
         checkOutput("div_latch_cycle", 64'(cycle), 64'(acceptCycle + 1));
         checkOutput("div_signed", {63'd0, o_div_signed}, {63'd0, (curOp == 3'd4 || curOp == 3'd6)});
         checkOutput("div_unit_ops", {o_unit_op1, o_unit_op2}, {curA, curB});
      end
   end

   task automatic waitIdle();
      bit done = 1'b0;
      for (int i = 0; i < 80 && !done; i++) begin
         if (!o_busy && sb.size() == 0) done = 1'b1;
         else @(negedge clock);
      end
      if (!done) begin
         checkOutput("idle_timeout", 64'd1, 64'd0);
         sb.delete();
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
      curOp = op; curA = a; curB = b;
      i_op = op; i_op1 = a; i_op2 = b;
      i_request = 1'b1;
      acceptCycle = cycle;
      #1 checkOutput("busy_on_request", {63'd0, o_busy}, 64'd1);
      repeat (hold) @(negedge clock);
      i_request = 1'b0;
      i_op = 3'd7; i_op1 = 32'hDEAD_BEEF; i_op2 = 32'hDEAD_BEEF;
   endtask

   task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp, input int lat,
                                input int ml, input int dl, input int hold = 1);
      int m0, d0;
      exp_t e;
      waitIdle();
      m0 = mulLatches;
      d0 = divLatches;
      e.result = exp; e.cycle = cycle + lat; e.name = name;
      sb.push_back(e);
      issue(op, a, b, hold);
      waitIdle();
      checkOutput({name, "_mul_latches"}, 64'(mulLatches - m0), 64'(ml));
      checkOutput({name, "_div_latches"}, 64'(divLatches - d0), 64'(dl));
   endtask

   task automatic checkQuiet(input string name);
      checkOutput({name, "_ready"}, {63'd0, o_ready}, 64'd0);
      checkOutput({name, "_busy"}, {63'd0, o_busy}, 64'd0);
      checkOutput({name, "_result"}, {32'd0, o_result}, 64'd0);
      checkOutput({name, "_unit_ops"}, {o_unit_op1, o_unit_op2}, 64'd0);
      checkOutput({name, "_ctrl"}, {60'd0, o_mul_latch, o_mul_signed, o_div_latch, o_div_signed}, 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      i_reset = 1'b0;
      checkQuiet("reset_state");

      applyStimulus("mul_7x6",       3'd0, 32'd7,         32'd6,         32'd42,        7, 1, 0);
      applyStimulus("mulhsu_neg1x2", 3'd2, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  7, 1, 0);
      applyStimulus("mulhsu_min",    3'd2, 32'h80000000,  32'h80000000,  32'hC0000000,  7, 1, 0);
      applyStimulus("mulhu_max",     3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  7, 1, 0);
      applyStimulus("mulhsu_reuse",  3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,
                    REUSE ? 1 : 7, REUSE ? 0 : 1, 0);
      applyStimulus("mulh_max",      3'd1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         7, 1, 0);
      applyStimulus("mul_after_mulh",3'd0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,
                    REUSE ? 1 : 7, REUSE ? 0 : 1, 0);
      applyStimulus("div_ovf",       3'd4, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1, 0, 0);
      applyStimulus("rem_ovf",       3'd6, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1, 0, 0);
      applyStimulus("divu_max",      3'd5, 32'h80000000,  32'hFFFFFFFF,  32'd0,         9, 0, 1);
      applyStimulus("remu_by0",      3'd7, 32'd5,         32'd0,         32'd5,         1, 0, 0);
      applyStimulus("divu_by0",      3'd5, 32'd5,         32'd0,         32'hFFFFFFFF,  1, 0, 0);
      applyStimulus("div_by0",       3'd4, 32'h12345678,  32'd0,         32'hFFFFFFFF,  1, 0, 0);
      applyStimulus("rem_by0",       3'd6, 32'hFFFFFFF0,  32'd0,         32'hFFFFFFF0,  1, 0, 0);
      applyStimulus("div_100_7",     3'd4, 32'd100,       32'd7,         32'd14,        9, 0, 1);
      applyStimulus("rem_100_7",     3'd6, 32'd100,       32'd7,         32'd2,
                    REUSE ? 1 : 9, 0, REUSE ? 0 : 1);
      applyStimulus("div_neg100_7",  3'd4, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  9, 0, 1);
      applyStimulus("rem_neg100_7",  3'd6, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFFE,
                    REUSE ? 1 : 9, 0, REUSE ? 0 : 1);

      // Reset while the multiplier is one cycle from finishing; its result must be dropped.
      waitIdle();
      issue(3'd0, 32'd9, 32'd9, 1);
      repeat (4) @(negedge clock);
      i_reset = 1'b1;
      @(negedge clock);
      i_reset = 1'b0;
      checkQuiet("reset_in_wait");
      repeat (3) @(negedge clock);
      checkOutput("unit_ready_after_reset", {63'd0, mulReady}, 64'd1);

      applyStimulus("rem_after_reset", 3'd6, 32'hFFFFFF9C, 32'd7,       32'hFFFFFFFE,  9, 0, 1);
      applyStimulus("mul_held",        3'd0, 32'd3,        32'd5,       32'd15,        7, 1, 0, 3);

      repeat (3) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/cpu_muldiv_sequencer.md
# cpu_muldiv_sequencer

Sequencer between the execute stage and the shared iterative multiply and divide units. It accepts one M-extension request at a time, latches the operands and issues the latch pulse to the correct unit. It resolves RISC-V divide corner cases without invoking the divider, corrects MULHSU from an unsigned product, and returns a single-cycle result pulse. It sits inside the execute stage; execute's complex-op path stalls on `o_busy` and retires on `o_ready`.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `i_clock` in 1: the single clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_request` in 1: one-cycle request pulse; accepted only in IDLE.
- `i_op` in 3: M-ext funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `i_op1`, `i_op2` in 32: operands; valid only in the request cycle.
- `o_busy` out 1: combinational; `i_request || state != IDLE`.
- `o_ready` out 1: one-cycle pulse; result valid.
- `o_result` out 32: result; held from the `o_ready` cycle until the next accepted request.
- `o_unit_op1`, `o_unit_op2` out 32: latched operands driven to both units.
- `o_mul_latch`, `o_mul_signed` out 1: multiplier start pulse and signedness.
- `i_mul_ready` in 1, `i_mul_result` in 64: multiplier status and product.
- `o_div_latch`, `o_div_signed` out 1: divider start pulse and signedness.
- `i_div_ready` in 1, `i_div_result`, `i_div_remainder` in 32: divider status and outputs.

## Operation
- States: IDLE, LATCH, WAIT, DONE.
- IDLE + `i_request`: register `i_op`, `i_op1`, `i_op2`, then classify the request.
  - Fast-path divide: go to DONE with the fast result.
  - Reuse hit (Configuration): go to DONE with the stored result.
  - Otherwise: go to LATCH.
- LATCH: raise the unit's latch for exactly one cycle, then go to WAIT.
  - `o_mul_signed` = 1 for MUL and MULH; 0 for MULHSU and MULHU.
  - `o_div_signed` = 1 for DIV and REM.
- WAIT: sample the selected unit's ready every cycle. On ready high, compute the result and go to DONE.
- DONE: pulse `o_ready`, drive `o_result`, go to IDLE.
- Unit contract: ready goes low the cycle after the latch pulse and stays low until the result is valid. `o_unit_op*` stay stable from LATCH through WAIT.
- Result selection:
  - MUL: product[31:0].
  - MULH, MULHU: product[63:32].
  - MULHSU: product[63:32] − (op1[31] ? op2 : 0), mod 2^32.
  - DIV/DIVU: `i_div_result`. REM/REMU: `i_div_remainder`.
- Fast-path divide cases:
  - op2 == 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op1.
  - Signed overflow, op1 = 0x80000000 and op2 = 0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- `i_request` while not IDLE is ignored; the requester is stalled by `o_busy`.

## Timing
- Accept at cycle t.
- Fast path or reuse hit: `o_ready` at t+1.
- Unit path: latch pulse at t+1; ready sampled from t+2.
  - If ready is first seen at cycle r, `o_ready` is at r+1.
  - Total latency = unit latency + 3.
- `o_busy` is high in the request cycle and stays high through the DONE cycle. It is low the cycle after DONE unless a new request arrives.
- Back-to-back: a request in the cycle after DONE is accepted.
- Reset (any state, including mid-WAIT) → IDLE next cycle.
  - `o_ready`, `o_mul_latch`, `o_div_latch`, both signed flags = 0.
  - `o_result`, `o_unit_op*` = 0; reuse tag invalid.
  - A unit result arriving after reset is ignored.

## Configuration
- `CPU_MULDIV_REUSE_EN` defined: keep a tag of the last unit-path request (op class, op1, op2, signedness) and the full unit outputs (64-bit product, or quotient plus remainder).
  - A request with the same class and operands hits, e.g. DIV after REM, or MUL after MULH with matching signedness.
  - A hit returns at t+1 with no latch pulse.
  - Fast-path requests neither hit nor update the tag.
  - Reset invalidates the tag.
- Undefined: no tag storage; every non-fast-path request goes through LATCH/WAIT.

## Test plan
- MUL 7 × 6, multiplier latency 4 → one `o_mul_latch` at t+1 with signed=1; `o_result` = 42 with `o_ready` at t+7.
- MULHSU op1 = 0xFFFFFFFF, op2 = 2 → unsigned latch; `o_result` = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → no `o_div_latch`; `o_result` = 0x80000000 at t+1. REMU 5 / 0 → `o_result` = 5 at t+1.
- DIV 100 / 7, then REM 100 / 7 → `o_result` 14, then 2.
  - With `CPU_MULDIV_REUSE_EN`: the second request makes no latch and returns at t+1.
  - Without it: two latches.
- Reset asserted in WAIT, `i_mul_ready` rising the next cycle → no `o_ready`; all outputs 0; the next request is accepted normally.
- `i_request` held high for 3 cycles during a multiply → exactly one accept; one `o_ready`.
